onchip_mem_arbiter: RTL and testbench

- Two-requester Avalon-MM arbiter in front of the single-port 32-bit on-chip RAM (15-bit word address, byte enables, 1-cycle read latency).
- Lets the Nios data master and a DMA/peripheral master share one RAM port.
- Grants one transfer per cycle using round-robin.
- Returns read data to the owning requester with readdatavalid.
- Blocks out-of-range accesses.

---
 rtl/onchip_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port on-chip RAM.
// It grants one transfer per cycle and returns read data one cycle after the
// transfer is accepted. Accesses at or above MEM_WORDS are accepted, but the
// RAM is not selected, so a write is dropped and a read returns zero.
module onchip_mem_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int MEM_WORDS = 32000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              addr_err
);

  // One extra bit lets the limit equal 2**ADDR_W without overflowing.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

  logic              req0;
  logic              req1;
  logic              gnt_valid;
  logic              gnt_idx;
  logic              last_grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic              sel_read;
  logic              in_range;
  logic              rd_pend;
  logic              rd_owner;
  logic              rd_oor;
  logic [DATA_W-1:0] ret_data;

  // Round-robin grant: under contention the requester that did not win last time wins now.
  always_comb begin
    req0      = m0_read | m0_write;
    req1      = m1_read | m1_write;
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    if (reset) begin
      gnt_valid = 1'b0;
      gnt_idx   = 1'b0;
    end else begin
      case ({req1, req0})
        2'b11: begin
          gnt_valid = 1'b1;
          gnt_idx   = ~last_grant;
        end
        2'b01: begin
          gnt_valid = 1'b1;
          gnt_idx   = 1'b0;
        end
        2'b10: begin
          gnt_valid = 1'b1;
          gnt_idx   = 1'b1;
        end
        default: begin
          gnt_valid = 1'b0;
          gnt_idx   = 1'b0;
        end
      endcase
    end
  end

  // Route the granted requester to the RAM. With no grant, gnt_idx is 0, so requester 0 drives the bus.
  always_comb begin
    if (gnt_idx) begin
      sel_addr  = m1_address;
      sel_be    = m1_byteenable;
      sel_wdata = m1_writedata;
      sel_write = gnt_valid & m1_write;
      sel_read  = gnt_valid & m1_read & ~m1_write;
    end else begin
      sel_addr  = m0_address;
      sel_be    = m0_byteenable;
      sel_wdata = m0_writedata;
      sel_write = gnt_valid & m0_write;
      sel_read  = gnt_valid & m0_read & ~m0_write;
    end
    in_range = ({1'b0, sel_addr} < MEM_LIMIT);
  end

  assign m0_waitrequest = ~(gnt_valid & ~gnt_idx);
  assign m1_waitrequest = ~(gnt_valid &  gnt_idx);
  assign mem_address    = sel_addr;
  assign mem_byteenable = sel_be;
  assign mem_writedata  = sel_wdata;
  assign mem_chipselect = gnt_valid & in_range;
  assign mem_write      = sel_write & in_range;

  // Arbitration history, one-stage read-return tracking and the error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
      rd_oor     <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      if (gnt_valid) begin
        last_grant <= gnt_idx;
      end
      rd_pend  <= sel_read;
      rd_owner <= gnt_idx;
      rd_oor   <= ~in_range;
      addr_err <= gnt_valid & ~in_range;
    end
  end

  // Steer the RAM's read data to the requester that owns the pending read. Out-of-range reads return zero.
  always_comb begin
    m0_readdatavalid = rd_pend & ~rd_owner;
    m1_readdatavalid = rd_pend &  rd_owner;
    if (rd_oor) begin
      ret_data = {DATA_W{1'b0}};
    end else begin
      ret_data = mem_readdata;
    end
    if (m0_readdatavalid) begin
      m0_readdata = ret_data;
    end else begin
      m0_readdata = {DATA_W{1'b0}};
    end
    if (m1_readdatavalid) begin
      m1_readdata = ret_data;
    end else begin
      m1_readdata = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: a RAM model with 1-cycle read latency,
// directed scenarios, then random traffic checked against a reference model.
module tb_onchip_mem_arbiter;

  localparam int MEMW = 32000;

  logic        clk;
  logic        reset;
  logic [14:0] m0_address;
  logic [3:0]  m0_byteenable;
  logic        m0_read;
  logic        m0_write;
  logic [31:0] m0_writedata;
  logic        m0_waitrequest;
  logic [31:0] m0_readdata;
  logic        m0_readdatavalid;
  logic [14:0] m1_address;
  logic [3:0]  m1_byteenable;
  logic        m1_read;
  logic        m1_write;
  logic [31:0] m1_writedata;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;
  logic        m1_readdatavalid;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        addr_err;

  logic [31:0] ram [0:32767];
  logic [31:0] ref_mem [0:32767];
  int          checks;
  int          errors;
  int          last_win;
  string       phase;

  onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: byte-lane writes, with registered read data one clock after the address.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  function automatic void ref_write(input int a, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endfunction

  // One bus cycle. It starts just after a negedge, checks the combinational
  // grant, then checks the registered/return outputs after the next posedge.
  task automatic cycle(input logic r0, input logic w0, input logic [14:0] a0,
                       input logic [3:0] be0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [14:0] a1,
                       input logic [3:0] be1, input logic [31:0] d1);
    int          win;
    int          a;
    bit          oor;
    bit          is_wr;
    bit          is_rd;
    logic [31:0] exp_rd;
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    #1;
    win = -1;
    if ((r0 | w0) && (r1 | w1)) win = (last_win == 0) ? 1 : 0;
    else if (r0 | w0)           win = 0;
    else if (r1 | w1)           win = 1;
    a      = (win == 1) ? int'(a1) : int'(a0);
    oor    = (a >= MEMW);
    is_wr  = (win == 0) ? w0 : (win == 1) ? w1 : 1'b0;
    is_rd  = (win >= 0) && !is_wr;
    exp_rd = 32'h0;
    if (is_rd && !oor) exp_rd = ref_mem[a];
    chk("wait0", m0_waitrequest, win != 0);
    chk("wait1", m1_waitrequest, win != 1);
    chk("chipselect", mem_chipselect, (win >= 0) && !oor);
    chk("mem_write", mem_write, (win >= 0) && is_wr && !oor);
    if (win >= 0) chk("mem_address", mem_address, a);
    if (win >= 0 && is_wr && !oor) ref_write(a, (win == 1) ? be1 : be0, (win == 1) ? d1 : d0);
    if (win >= 0) last_win = win;
    @(posedge clk);
    #1;
    chk("rdv0", m0_readdatavalid, is_rd && win == 0);
    chk("rdv1", m1_readdatavalid, is_rd && win == 1);
    chk("rdata0", m0_readdata, (is_rd && win == 0) ? exp_rd : 32'h0);
    chk("rdata1", m1_readdata, (is_rd && win == 1) ? exp_rd : 32'h0);
    chk("addr_err", addr_err, (win >= 0) && oor);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
  endtask
  task automatic rd0(input logic [14:0] a);
    cycle(1'b1, 1'b0, a, 4'hF, 32'h0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
  endtask
  task automatic wr0(input logic [14:0] a, input logic [3:0] be, input logic [31:0] d);
    cycle(1'b0, 1'b1, a, be, d, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
  endtask
  task automatic rd1(input logic [14:0] a);
    cycle(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b1, 1'b0, a, 4'hF, 32'h0);
  endtask
  task automatic wr1(input logic [14:0] a, input logic [3:0] be, input logic [31:0] d);
    cycle(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b0, 1'b1, a, be, d);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_win = 1;
  endtask

  function automatic logic [14:0] rand_addr();
    logic [14:0] special [0:2];
    special[0] = 15'd31999; special[1] = 15'd32000; special[2] = 15'd32767;
    if ($urandom_range(0, 9) == 0) return special[$urandom_range(0, 2)];
    return 15'($urandom_range(0, 15));
  endfunction

  initial begin
    checks = 0; errors = 0; last_win = 1;
    for (int i = 0; i < 32768; i++) begin ram[i] = 32'h0; ref_mem[i] = 32'h0; end
    mem_readdata = 32'h0;
    reset = 1'b1;
    m0_address = 15'h5; m0_byteenable = 4'hF; m0_read = 1'b1; m0_write = 1'b0; m0_writedata = 32'h0;
    m1_address = 15'h6; m1_byteenable = 4'hF; m1_read = 1'b0; m1_write = 1'b1; m1_writedata = 32'h1;

    phase = "reset";
    #2;
    chk("wait0", m0_waitrequest, 1'b1);
    chk("wait1", m1_waitrequest, 1'b1);
    chk("rdv0", m0_readdatavalid, 1'b0);
    chk("rdv1", m1_readdatavalid, 1'b0);
    chk("rdata0", m0_readdata, 32'h0);
    chk("rdata1", m1_readdata, 32'h0);
    chk("addr_err", addr_err, 1'b0);
    chk("chipselect", mem_chipselect, 1'b0);
    chk("mem_write", mem_write, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    phase = "preload";
    wr1(15'h1, 4'hF, 32'hA0A0_0001);
    wr1(15'h2, 4'hF, 32'hA0A0_0002);
    wr1(15'h20, 4'hF, 32'h1111_1111);
    reset_dut();

    phase = "contention";
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b0, 15'h1, 4'hF, 32'h0, 1'b1, 1'b0, 15'h2, 4'hF, 32'h0);

    phase = "write_read";
    wr0(15'h10, 4'hF, 32'hDEAD_BEEF);
    rd0(15'h10);

    phase = "byteenable";
    wr0(15'h100, 4'hF, 32'hFFFF_FFFF);
    wr0(15'h100, 4'h1, 32'h0000_0012);
    rd0(15'h100);
    chk("be_value", ref_mem[256], 32'hFFFF_FF12);

    phase = "out_of_range";
    wr1(15'd31999, 4'hF, 32'h1234_5678);
    wr1(15'd32000, 4'hF, 32'h8765_4321);
    rd1(15'd32767);
    rd1(15'd31999);

    phase = "rd_wr_overlap";
    rd0(15'h20);
    wr1(15'h20, 4'hF, 32'h2222_2222);
    rd1(15'h20);

    phase = "reset_mid_read";
    m0_read = 1'b1; m0_write = 1'b0; m0_address = 15'h10;
    m1_read = 1'b0; m1_write = 1'b0;
    #1;
    chk("accept0", m0_waitrequest, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rdv0", m0_readdatavalid, 1'b0);
    chk("rdata0", m0_readdata, 32'h0);
    chk("wait0", m0_waitrequest, 1'b1);
    chk("chipselect", mem_chipselect, 1'b0);
    @(posedge clk);
    #1;
    chk("rdv0_held", m0_readdatavalid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    last_win = 1;
    idle();
    cycle(1'b1, 1'b0, 15'h1, 4'hF, 32'h0, 1'b1, 1'b0, 15'h2, 4'hF, 32'h0);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(),
            4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(),
            4'($urandom_range(0, 15)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
